// File: rtl/stack_seq.sv
`default_nettype none

`ifndef SC_N
`define SC_N   2
`define SC_NOP 2'b00
`define SC_PUS 2'b01
`define SC_POP 2'b10
`define SC_TOP 2'b11
`endif

// ============================================================================
//  Module   : stack_seq
//  Purpose  : Sequencer owning the operand stack's command port and shared
//             tri-state data bus. Accepts one request at a time (PUSH, OP,
//             PEEK, DROP), issues the stack command sequence, captures read
//             data, computes binary-op results, tracks depth and rejects
//             requests that would under/overflow the stack.
//  Ports    : clk, rst                       - clock, sync active-high reset
//             req_valid/req_ready            - request handshake
//             req_kind/req_op/req_data       - request payload
//             rsp_valid/rsp_data/rsp_err     - one-cycle completion
//             depth                          - current entry count
//             stk_cmd/stk_data               - stack command and data bus
//  Revision : 1.0 - initial release
// ============================================================================
module stack_seq #(
    parameter int N     = 16,
    parameter int DEPTH = 64
) (
    input  wire                         clk,
    input  wire                         rst,
    input  wire                         req_valid,
    output logic                        req_ready,
    input  wire  [1:0]                  req_kind,
    input  wire  [1:0]                  req_op,
    input  wire  [N-1:0]                req_data,
    output logic                        rsp_valid,
    output logic [N-1:0]                rsp_data,
    output logic                        rsp_err,
    output logic [$clog2(DEPTH+1)-1:0]  depth,
    output logic [`SC_N-1:0]            stk_cmd,
    inout  wire  [N-1:0]                stk_data
);

    localparam int DW = $clog2(DEPTH + 1);

    localparam logic [DW-1:0] c_FULL = DW'(DEPTH);
    localparam logic [DW-1:0] c_ONE  = DW'(1);
    localparam logic [DW-1:0] c_TWO  = DW'(2);

    localparam logic [1:0] c_KIND_PUSH = 2'b00;
    localparam logic [1:0] c_KIND_OP   = 2'b01;
    localparam logic [1:0] c_KIND_DROP = 2'b11;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_SUB = 2'b01;
    localparam logic [1:0] c_OP_AND = 2'b10;

    // The completion cycle is folded into the return to IDLE, so there is
    // no separate DONE encoding: rsp_valid is registered on the way back.
    localparam logic [3:0] c_IDLE    = 4'd0;
    localparam logic [3:0] c_WR_PUSH = 4'd1;
    localparam logic [3:0] c_RD_B    = 4'd2;
    localparam logic [3:0] c_CAP_B   = 4'd3;
    localparam logic [3:0] c_RD_A    = 4'd4;
    localparam logic [3:0] c_CAP_A   = 4'd5;
    localparam logic [3:0] c_WR_RES  = 4'd6;
    localparam logic [3:0] c_RD_T    = 4'd7;
    localparam logic [3:0] c_CAP_T   = 4'd8;
    localparam logic [3:0] c_ERR     = 4'd9;

    logic [3:0]       r_state;
    logic [DW-1:0]    r_depth;
    logic [1:0]       r_op;
    logic             r_drop;
    logic [N-1:0]     r_opb;
    logic [N-1:0]     r_wdata;
    logic             r_drv;
    logic [`SC_N-1:0] r_stk_cmd;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [N-1:0]     r_rsp_data;
    logic [N-1:0]     w_result;

    // Operand A is taken straight off the bus in CAP_A; B was latched in CAP_B.
    always_comb begin
        w_result = '0;
        case (r_op)
            c_OP_ADD: w_result = stk_data + r_opb;
            c_OP_SUB: w_result = stk_data - r_opb;
            c_OP_AND: w_result = stk_data & r_opb;
            default:  w_result = stk_data ^ r_opb;
        endcase
    end

    // Command, bus enable and write data are registered together with the
    // state transition so they are valid for the whole of the target state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_depth     <= '0;
            r_op        <= 2'b00;
            r_drop      <= 1'b0;
            r_opb       <= '0;
            r_wdata     <= '0;
            r_drv       <= 1'b0;
            r_stk_cmd   <= `SC_NOP;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_stk_cmd   <= `SC_NOP;
            r_drv       <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_op   <= req_op;
                        r_drop <= (req_kind == c_KIND_DROP);
                        if (req_kind == c_KIND_PUSH) begin
                            if (r_depth == c_FULL) begin
                                r_state <= c_ERR;
                            end else begin
                                r_state   <= c_WR_PUSH;
                                r_stk_cmd <= `SC_PUS;
                                r_drv     <= 1'b1;
                                r_wdata   <= req_data;
                            end
                        end else if (req_kind == c_KIND_OP) begin
                            if (r_depth < c_TWO) begin
                                r_state <= c_ERR;
                            end else begin
                                r_state   <= c_RD_B;
                                r_stk_cmd <= `SC_POP;
                            end
                        end else begin
                            if (r_depth == '0) begin
                                r_state <= c_ERR;
                            end else begin
                                r_state   <= c_RD_T;
                                r_stk_cmd <= (req_kind == c_KIND_DROP) ? `SC_POP : `SC_TOP;
                            end
                        end
                    end
                end
                c_WR_PUSH: begin
                    r_depth     <= r_depth + c_ONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= r_wdata;
                    r_state     <= c_IDLE;
                end
                c_RD_B: r_state <= c_CAP_B;
                c_CAP_B: begin
                    r_opb     <= stk_data;
                    r_stk_cmd <= `SC_POP;
                    r_state   <= c_RD_A;
                end
                c_RD_A: r_state <= c_CAP_A;
                c_CAP_A: begin
                    r_wdata   <= w_result;
                    r_stk_cmd <= `SC_PUS;
                    r_drv     <= 1'b1;
                    r_state   <= c_WR_RES;
                end
                c_WR_RES: begin
                    // Two pops and one push: net one entry fewer.
                    r_depth     <= r_depth - c_ONE;
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= r_wdata;
                    r_state     <= c_IDLE;
                end
                c_RD_T: begin
                    if (r_drop) begin
                        r_depth <= r_depth - c_ONE;
                    end
                    r_state <= c_CAP_T;
                end
                c_CAP_T: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b0;
                    r_rsp_data  <= stk_data;
                    r_state     <= c_IDLE;
                end
                c_ERR: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_err   <= 1'b1;
                    r_rsp_data  <= '0;
                    r_state     <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == c_IDLE);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign depth     = r_depth;
    assign stk_cmd   = r_stk_cmd;
    assign stk_data  = r_drv ? r_wdata : {N{1'bz}};

endmodule

`default_nettype wire
